vend_txn_sequencer: RTL and testbench
=====================================

# vend_txn_sequencer

Transaction sequencer for the vending machine datapath. Accepts validated coin strobes and the selected product price, keeps the running credit, and decides when to dispense. It then hands off dispensing over a req/ack handshake, pays change one unit at a time, and keeps the running sales total. It sits between the coin/price decoders and the dispenser and change hoppers, and replaces ad-hoc sequencing in the top level.

## Interface
- CREDIT_MAX, 99: maximum credit; a coin that would exceed it is rejected.
- TIMEOUT_CYCLES, 1000: idle cycles in CREDIT before an automatic refund.
- ALARM_CYCLES, 4: length of the alarm pulse, in cycles.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- coin_pulse  in  1  one-cycle strobe; one coin inserted (already debounced and edge-detected upstream).
- coin_value  in  8  value of that coin, valid with coin_pulse; 0 = unrecognised coin.
- price  in  8  price of the current selection; sampled on confirm_pulse.
- confirm_pulse  in  1  one-cycle purchase request.
- cancel_pulse  in  1  one-cycle refund request.
- dispense_ack  in  1  dispenser completion; level, sampled while dispense_req=1.
- dispense_req  out  1  dispense request; held until ack.
- change_pulse  out  1  one cycle per change unit released.
- change_remaining  out  8  change units still owed.
- credit  out  8  current credit.
- sales_total  out  8  cumulative sales, modulo 256.
- alarm  out  1  error indication.
- state  out  2  IDLE=0, CREDIT=1, VEND=2, CHANGE=3.

## Operation
- IDLE (credit=0):
  - coin_pulse with coin_value≠0 → credit=coin_value, go to CREDIT.
  - coin_value=0 → alarm.
  - confirm_pulse → alarm.
  - cancel_pulse → ignored.
- CREDIT:
  - Accepted coin: credit+=coin_value, only if the 9-bit sum is ≤ CREDIT_MAX. Otherwise reject: credit unchanged, alarm.
  - coin_value=0 → alarm.
  - confirm_pulse with price=0 or price>credit → alarm, stay in CREDIT.
  - confirm_pulse otherwise → credit-=price, sales_total+=price (wraps mod 256), go to VEND.
  - cancel_pulse or timeout → change_remaining=credit, credit=0, go to CHANGE.
- Same-cycle priority in CREDIT is cancel > confirm > coin. A coin_pulse arriving with an acted-on cancel or confirm is dropped and raises alarm.
- VEND:
  - dispense_req=1 until dispense_ack is sampled high.
  - On the ack cycle: change_remaining=credit, credit=0, go to CHANGE.
  - coin_pulse → rejected with alarm; confirm_pulse and cancel_pulse ignored.
- CHANGE:
  - Entered with N>0 units: change_pulse is high on CHANGE cycles 0, 2, …, 2N−2, and change_remaining decrements in each of those cycles.
  - After the last unit, go to IDLE, which is visible at CHANGE cycle 2N.
  - Entered with N=0: go to IDLE on the next cycle, with no change_pulse.
  - coin_pulse → rejected with alarm; other inputs ignored.
- Timeout counter:
  - Counts cycles spent in CREDIT.
  - Cleared on entry to CREDIT and on every coin_pulse or confirm_pulse, including rejected ones.
  - Fires when the count reaches TIMEOUT_CYCLES−1.
- Alarm:
  - Any alarm event drives alarm high for ALARM_CYCLES cycles.
  - A new event during the pulse restarts the count.

## Timing
- All outputs are registered. An input strobe sampled at edge k is reflected in outputs after edge k (one-cycle latency).
- dispense_req:
  - Rises in the first cycle of VEND.
  - Falls in the cycle after dispense_ack is sampled high.
  - With ack tied high, VEND lasts exactly 1 cycle.
- Reset (asynchronous): state=IDLE; credit, change_remaining and sales_total = 0; dispense_req, change_pulse and alarm = 0; timeout and alarm counters cleared.
- Reset mid-VEND or mid-CHANGE abandons the transaction and the owed change. sales_total clears.
- Credit arithmetic uses a 9-bit intermediate, so no 8-bit wrap can admit a coin.

## Test plan
- Coins 5 then 2 → credit 5, then 7. Confirm with price=6 → credit=1, sales_total=6, VEND. Ack after 3 cycles → one change_pulse, IDLE.
- Credit 3, confirm with price=5 → alarm high for 4 cycles; credit stays 3, state stays CREDIT.
- Credit 97, coin 5 → rejected: alarm, credit stays 97. Cancel → change_remaining=97 → 97 change_pulses over 194 cycles, then IDLE.
- Coin 4, then no activity for TIMEOUT_CYCLES → auto refund: CHANGE with 4 units.
- Same cycle, credit 10: confirm (price 10) plus coin 2 → VEND with credit 0 and alarm. Same cycle: cancel plus confirm → CHANGE with 10 units, sales_total unchanged.
- Sales of 200 then 100 → sales_total=44. Assert rst_n in VEND → all outputs zero immediately, state IDLE.

Source files
------------

// File: rtl/vend_txn_sequencer.sv
// Vending transaction sequencer: keeps the running credit, decides when to vend,
// runs the dispense req/ack handshake, pays change one unit every other cycle and
// keeps a modulo-256 sales total. Every output is driven straight from a register.
//
// Handshake: o_dispense_req is raised on entry to VEND and held; i_dispense_ack is
// a level sampled on each clock while o_dispense_req=1. The edge that samples
// ack high is the one that drops o_dispense_req and moves the FSM to CHANGE.
module vend_txn_sequencer #(
  parameter int CREDIT_MAX     = 99,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int ALARM_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_coin_pulse,
  input  logic [7:0] i_coin_value,
  input  logic [7:0] i_price,
  input  logic       i_confirm_pulse,
  input  logic       i_cancel_pulse,
  input  logic       i_dispense_ack,
  output logic       o_dispense_req,
  output logic       o_change_pulse,
  output logic [7:0] o_change_remaining,
  output logic [7:0] o_credit,
  output logic [7:0] o_sales_total,
  output logic       o_alarm,
  output logic [1:0] o_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CREDIT = 2'd1;
  localparam logic [1:0] ST_VEND   = 2'd2;
  localparam logic [1:0] ST_CHANGE = 2'd3;

  logic [1:0]  r_state, w_next_state;
  logic [7:0]  r_credit, w_credit_nxt;
  logic [7:0]  r_change_rem, w_change_rem_nxt;
  logic [7:0]  r_sales, w_sales_nxt;
  logic        r_req, w_req_nxt;
  logic        r_pulse, w_pulse_nxt;
  logic [15:0] r_tcnt, w_tcnt_nxt;
  logic [7:0]  r_acnt;
  logic        r_alarm, w_alarm_evt;

  // 9-bit sum so an 8-bit wrap can never sneak a coin under the credit limit.
  logic [8:0] w_sum;
  logic       w_timeout, w_cancel_act, w_price_ok, w_vend_act;

  assign w_sum        = {1'b0, r_credit} + {1'b0, i_coin_value};
  assign w_timeout    = (r_state == ST_CREDIT) && (r_tcnt == 16'(TIMEOUT_CYCLES - 1));
  assign w_cancel_act = i_cancel_pulse || w_timeout;
  assign w_price_ok   = (i_price != 8'd0) && (i_price <= r_credit);
  assign w_vend_act   = i_confirm_pulse && !w_cancel_act && w_price_ok;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; in CREDIT a cancel/timeout beats a confirm.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (i_coin_pulse && (i_coin_value != 8'd0)) w_next_state = ST_CREDIT;
      ST_CREDIT: begin
        if (w_cancel_act)    w_next_state = ST_CHANGE;
        else if (w_vend_act) w_next_state = ST_VEND;
      end
      ST_VEND:   if (i_dispense_ack) w_next_state = ST_CHANGE;
      ST_CHANGE: if (!r_pulse && (r_change_rem == 8'd0)) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and counters.
  always_comb begin
    w_credit_nxt     = r_credit;
    w_change_rem_nxt = r_change_rem;
    w_sales_nxt      = r_sales;
    w_req_nxt        = r_req;
    w_pulse_nxt      = 1'b0;
    w_tcnt_nxt       = 16'd0;
    w_alarm_evt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_coin_pulse) begin
          if (i_coin_value == 8'd0) w_alarm_evt  = 1'b1;
          else                      w_credit_nxt = i_coin_value;
        end
        if (i_confirm_pulse) w_alarm_evt = 1'b1;
      end
      ST_CREDIT: begin
        // Any coin or confirm, accepted or not, restarts the idle timer.
        w_tcnt_nxt = (i_coin_pulse || i_confirm_pulse) ? 16'd0 : r_tcnt + 16'd1;
        if (w_cancel_act) begin
          w_change_rem_nxt = r_credit;
          w_credit_nxt     = 8'd0;
          w_pulse_nxt      = (r_credit != 8'd0);
          w_tcnt_nxt       = 16'd0;
          if (i_coin_pulse) w_alarm_evt = 1'b1;
        end else if (w_vend_act) begin
          w_credit_nxt = r_credit - i_price;
          w_sales_nxt  = r_sales + i_price;
          w_req_nxt    = 1'b1;
          w_tcnt_nxt   = 16'd0;
          if (i_coin_pulse) w_alarm_evt = 1'b1;
        end else begin
          // A rejected confirm is not acted on, so a same-cycle coin still counts.
          if (i_confirm_pulse) w_alarm_evt = 1'b1;
          if (i_coin_pulse) begin
            if ((i_coin_value == 8'd0) || (w_sum > 9'(CREDIT_MAX))) w_alarm_evt  = 1'b1;
            else                                                    w_credit_nxt = w_sum[7:0];
          end
        end
      end
      ST_VEND: begin
        if (i_dispense_ack) begin
          w_req_nxt        = 1'b0;
          w_change_rem_nxt = r_credit;
          w_credit_nxt     = 8'd0;
          w_pulse_nxt      = (r_credit != 8'd0);
        end
        if (i_coin_pulse) w_alarm_evt = 1'b1;
      end
      ST_CHANGE: begin
        // Pulse cycles alternate with gap cycles; the count drops after each pulse.
        if (r_pulse)                    w_change_rem_nxt = r_change_rem - 8'd1;
        else if (r_change_rem != 8'd0)  w_pulse_nxt      = 1'b1;
        if (i_coin_pulse) w_alarm_evt = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and alarm-stretch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit     <= 8'd0;
      r_change_rem <= 8'd0;
      r_sales      <= 8'd0;
      r_req        <= 1'b0;
      r_pulse      <= 1'b0;
      r_tcnt       <= 16'd0;
      r_acnt       <= 8'd0;
      r_alarm      <= 1'b0;
    end else begin
      r_credit     <= w_credit_nxt;
      r_change_rem <= w_change_rem_nxt;
      r_sales      <= w_sales_nxt;
      r_req        <= w_req_nxt;
      r_pulse      <= w_pulse_nxt;
      r_tcnt       <= w_tcnt_nxt;
      if (w_alarm_evt) begin
        r_alarm <= 1'b1;
        r_acnt  <= 8'(ALARM_CYCLES - 1);
      end else if (r_acnt != 8'd0) begin
        r_acnt  <= r_acnt - 8'd1;
      end else begin
        r_alarm <= 1'b0;
      end
    end
  end

  assign o_state            = r_state;
  assign o_credit           = r_credit;
  assign o_change_remaining = r_change_rem;
  assign o_sales_total      = r_sales;
  assign o_dispense_req     = r_req;
  assign o_change_pulse     = r_pulse;
  assign o_alarm            = r_alarm;

endmodule

// File: tb/tb_vend_txn_sequencer.sv
// Bench for vend_txn_sequencer: directed scenarios followed by random
// transactions checked against an arithmetic model of credit, sales and change.
module tb_vend_txn_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_pulse, confirm_pulse, cancel_pulse, dispense_ack;
  logic [7:0] coin_value, price;
  logic       dispense_req, change_pulse, alarm;
  logic [7:0] change_remaining, credit, sales_total;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  vend_txn_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .i_coin_pulse(coin_pulse), .i_coin_value(coin_value), .i_price(price),
    .i_confirm_pulse(confirm_pulse), .i_cancel_pulse(cancel_pulse),
    .i_dispense_ack(dispense_ack),
    .o_dispense_req(dispense_req), .o_change_pulse(change_pulse),
    .o_change_remaining(change_remaining), .o_credit(credit),
    .o_sales_total(sales_total), .o_alarm(alarm), .o_state(state)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver tasks.
  task automatic do_coin(input logic [7:0] v);
    coin_pulse = 1'b1; coin_value = v; tick();
    coin_pulse = 1'b0; coin_value = 8'd0;
  endtask

  task automatic do_confirm(input logic [7:0] p);
    confirm_pulse = 1'b1; price = p; tick();
    confirm_pulse = 1'b0;
  endtask

  task automatic do_cancel();
    cancel_pulse = 1'b1; tick();
    cancel_pulse = 1'b0;
  endtask

  // Scoreboard: pops the owed change and counts pulses/cycles until IDLE.
  task automatic drain(input string tag);
    int n, pulses, cyc;
    n = int'(exp_q.pop_front());
    pulses = 0; cyc = 0;
    chk({tag, "_rem"}, int'(change_remaining), n);
    while (state != 2'd0 && cyc < 2 * n + 8) begin
      if (change_pulse) pulses++;
      tick();
      cyc++;
    end
    chk({tag, "_pulses"}, pulses, n);
    chk({tag, "_cycles"}, cyc, (n == 0) ? 1 : 2 * n);
    chk({tag, "_idle"}, int'(state), 0);
  endtask

  int m_credit, m_sales, v, p, waits;

  initial begin
    rst_n = 1'b0;
    coin_pulse = 0; coin_value = 0; price = 0;
    confirm_pulse = 0; cancel_pulse = 0; dispense_ack = 0;
    tick(); tick();
    chk("rst_state", int'(state), 0);
    chk("rst_credit", int'(credit), 0);
    chk("rst_sales", int'(sales_total), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_req", int'(dispense_req), 0);
    rst_n = 1'b1;
    tick();

    // Coins 5, 2, buy at 6, late ack, one unit of change.
    do_coin(8'd5);
    chk("c5_credit", int'(credit), 5);
    chk("c5_state", int'(state), 1);
    do_coin(8'd2);
    chk("c7_credit", int'(credit), 7);
    do_confirm(8'd6);
    chk("buy6_credit", int'(credit), 1);
    chk("buy6_sales", int'(sales_total), 6);
    chk("buy6_state", int'(state), 2);
    chk("buy6_req", int'(dispense_req), 1);
    repeat (3) tick();
    chk("req_hold", int'(dispense_req), 1);
    dispense_ack = 1'b1; tick(); dispense_ack = 1'b0;
    chk("ack_req_low", int'(dispense_req), 0);
    chk("ack_state", int'(state), 3);
    exp_q.push_back(8'd1);
    drain("buy6");

    // Price above credit: 4-cycle alarm, credit kept.
    do_coin(8'd3);
    do_confirm(8'd5);
    chk("hi_alarm1", int'(alarm), 1);
    chk("hi_credit", int'(credit), 3);
    chk("hi_state", int'(state), 1);
    tick(); tick(); tick();
    chk("hi_alarm4", int'(alarm), 1);
    tick();
    chk("hi_alarm_off", int'(alarm), 0);
    do_cancel();
    exp_q.push_back(8'd3);
    drain("hi");

    // Over-limit coin rejected, then a 97-unit refund.
    do_coin(8'd50); do_coin(8'd47);
    chk("c97_credit", int'(credit), 97);
    do_coin(8'd5);
    chk("ovr_alarm", int'(alarm), 1);
    chk("ovr_credit", int'(credit), 97);
    do_cancel();
    chk("c97_state", int'(state), 3);
    exp_q.push_back(8'd97);
    drain("c97");

    // Automatic refund after the idle timeout.
    do_coin(8'd4);
    repeat (999) tick();
    chk("to_before", int'(state), 1);
    tick();
    chk("to_state", int'(state), 3);
    exp_q.push_back(8'd4);
    drain("to");

    // Confirm + coin in one cycle: vend wins, coin dropped with alarm.
    do_coin(8'd10);
    repeat (5) tick();
    confirm_pulse = 1'b1; price = 8'd10; coin_pulse = 1'b1; coin_value = 8'd2;
    tick();
    confirm_pulse = 1'b0; coin_pulse = 1'b0; coin_value = 8'd0;
    chk("cc_state", int'(state), 2);
    chk("cc_credit", int'(credit), 0);
    chk("cc_alarm", int'(alarm), 1);
    chk("cc_sales", int'(sales_total), 16);
    dispense_ack = 1'b1; tick(); dispense_ack = 1'b0;
    exp_q.push_back(8'd0);
    drain("cc");

    // Cancel + confirm in one cycle: refund wins, no sale.
    do_coin(8'd10);
    cancel_pulse = 1'b1; confirm_pulse = 1'b1; price = 8'd10;
    tick();
    cancel_pulse = 1'b0; confirm_pulse = 1'b0;
    chk("xc_state", int'(state), 3);
    chk("xc_sales", int'(sales_total), 16);
    exp_q.push_back(8'd10);
    drain("xc");

    // Sales wrap: 200 then 100 more from a fresh reset gives 44.
    rst_n = 1'b0; #1; rst_n = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      p = (i == 2) ? 2 : ((i == 4) ? 1 : 99);
      do_coin(8'(p)); do_confirm(8'(p));
      dispense_ack = 1'b1; tick(); dispense_ack = 1'b0;
      exp_q.push_back(8'd0);
      drain("wrap");
      if (i == 2) chk("sales200", int'(sales_total), 200);
    end
    chk("sales44", int'(sales_total), 44);

    // Reset while vending clears everything at once.
    do_coin(8'd9); do_confirm(8'd3);
    chk("rv_state", int'(state), 2);
    rst_n = 1'b0; #1;
    chk("rv_state0", int'(state), 0);
    chk("rv_req0", int'(dispense_req), 0);
    chk("rv_credit0", int'(credit), 0);
    chk("rv_sales0", int'(sales_total), 0);
    chk("rv_rem0", int'(change_remaining), 0);
    rst_n = 1'b1;
    tick();

    // Random transactions against the arithmetic model.
    m_sales = 0;
    for (int t = 0; t < 40; t++) begin
      m_credit = 0;
      for (int c = 0, nc = $urandom_range(1, 4); c < nc; c++) begin
        v = $urandom_range(0, 40);
        do_coin(8'(v));
        if (v != 0 && m_credit + v <= 99) begin
          m_credit += v;
          chk("r_coin_alarm", int'(alarm), 0);
        end else begin
          chk("r_coin_alarm", int'(alarm), 1);
        end
        chk("r_credit", int'(credit), m_credit);
        chk("r_state", int'(state), (m_credit == 0) ? 0 : 1);
        repeat (5) tick();
      end
      if (m_credit == 0) continue;
      if ($urandom_range(0, 2) == 0) begin
        do_cancel();
        chk("r_cancel_state", int'(state), 3);
        chk("r_cancel_sales", int'(sales_total), m_sales);
        exp_q.push_back(8'(m_credit));
        drain("r_cancel");
      end else begin
        p = $urandom_range(0, m_credit + 5);
        do_confirm(8'(p));
        if (p == 0 || p > m_credit) begin
          chk("r_rej_alarm", int'(alarm), 1);
          chk("r_rej_state", int'(state), 1);
          chk("r_rej_credit", int'(credit), m_credit);
          repeat (5) tick();
          do_cancel();
          exp_q.push_back(8'(m_credit));
          drain("r_rej");
        end else begin
          m_sales = (m_sales + p) % 256;
          chk("r_vend_state", int'(state), 2);
          chk("r_vend_credit", int'(credit), m_credit - p);
          chk("r_vend_sales", int'(sales_total), m_sales);
          waits = $urandom_range(0, 3);
          repeat (waits) tick();
          chk("r_vend_req", int'(dispense_req), 1);
          dispense_ack = 1'b1; tick(); dispense_ack = 1'b0;
          exp_q.push_back(8'(m_credit - p));
          drain("r_vend");
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case the DUT wedges somewhere the bounded loops cannot see.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
